// File: rtl/regfile_ctx_pkg.sv
// Shared encodings for the context-switching register file: operation codes,
// copy FSM states and copy direction.
package regfile_ctx_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LLI   = 3'd1,
    OP_LUI   = 3'd2,
    OP_ALU   = 3'd3,
    OP_TOACC = 3'd4,
    OP_MOV   = 3'd5,
    OP_LOAD  = 3'd6,
    OP_INC   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SAVING    = 2'd1,
    ST_RESTORING = 2'd2
  } state_e;

  localparam logic COPY_DIR_SAVE    = 1'b0;
  localparam logic COPY_DIR_RESTORE = 1'b1;

endpackage

// File: rtl/ctx_copy_fsm.sv
// Sequences a whole-bank copy between the live and shadow register banks,
// one register per cycle, and reports progress through BUSY and DONE.
module ctx_copy_fsm
  import regfile_ctx_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SAVE,
  input  logic             RESTORE,
  output logic             copy_en,
  output logic             copy_dir,
  output logic [IDX_W-1:0] copy_idx,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_e           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r;
  logic             done_r;

  // Copy state machine; requests are only sampled in IDLE, so mid-copy requests drop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          idx_r  <= '0;
          if (SAVE) begin
            state_r <= ST_SAVING;
            busy_r  <= 1'b1;
          end else if (RESTORE) begin
            state_r <= ST_RESTORING;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SAVING, ST_RESTORING: begin
          if (idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign copy_en  = (state_r != ST_IDLE);
  assign copy_dir = (state_r == ST_RESTORING) ? COPY_DIR_RESTORE : COPY_DIR_SAVE;
  assign copy_idx = idx_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;

endmodule

// File: rtl/regfile_ctx.sv
// Accumulator register file with pointer post-increment and a shadow bank
// that is saved/restored one register per cycle for interrupt entry and exit.
module regfile_ctx
  import regfile_ctx_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  localparam int IMM_W  = DATA_W / 2,
  localparam int SEL_W  = $clog2(NUM_REGS),
  localparam int ADDR_W = 2 * DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [2:0]        OP,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [IMM_W-1:0]  IMM,
  input  logic [DATA_W-1:0] ANS,
  input  logic [DATA_W-1:0] MEMIN,
  input  logic              SAVE,
  input  logic              RESTORE,
  output logic [DATA_W-1:0] ACC,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              DONE
);

  logic [DATA_W-1:0] live_r   [NUM_REGS];
  logic [DATA_W-1:0] shadow_r [NUM_REGS];

  logic              copy_en_s;
  logic              copy_dir_s;
  logic [SEL_W-1:0]  copy_idx_s;
  logic [ADDR_W-1:0] ptr_s;
  logic [ADDR_W-1:0] ptr_inc_s;

  ctx_copy_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_copy_fsm (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .SAVE     (SAVE),
    .RESTORE  (RESTORE),
    .copy_en  (copy_en_s),
    .copy_dir (copy_dir_s),
    .copy_idx (copy_idx_s),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  assign ptr_s     = {live_r[1], live_r[0]};
  assign ptr_inc_s = ptr_s + ADDR_W'(1);

  // Live bank: restore copy has priority; OPs only execute while no copy is running.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_r[i] <= '0;
      end
    end else if (copy_en_s) begin
      if (copy_dir_s == COPY_DIR_RESTORE) begin
        live_r[copy_idx_s] <= shadow_r[copy_idx_s];
      end
    end else begin
      case (op_e'(OP))
        OP_NOP:   ;
        OP_LLI:   live_r[0] <= {live_r[0][DATA_W-1:IMM_W], IMM};
        OP_LUI:   live_r[0] <= {IMM, live_r[0][IMM_W-1:0]};
        OP_ALU:   live_r[0] <= ANS;
        OP_TOACC: live_r[0] <= live_r[SEL];
        OP_MOV:   live_r[SEL] <= live_r[0];
        OP_LOAD:  live_r[SEL] <= MEMIN;
        OP_INC:   {live_r[1], live_r[0]} <= ptr_inc_s;
        default:  ;
      endcase
    end
  end

  // Shadow bank captures the live bank during a save copy.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= '0;
      end
    end else if (copy_en_s && (copy_dir_s == COPY_DIR_SAVE)) begin
      shadow_r[copy_idx_s] <= live_r[copy_idx_s];
    end
  end

  assign ACC     = live_r[0];
  assign ADDRESS = ptr_s;
  assign RDATA   = live_r[SEL];

endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx: directed scenarios plus random OP/SAVE/RESTORE
// traffic checked against an array-based model, and a small 16-bit/4-register instance.
module tb_regfile_ctx;
  import regfile_ctx_pkg::*;

  localparam int DW = 8;
  localparam int NR = 16;
  localparam int SW = 4;
  localparam int IW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET_N;
  logic [2:0]    op;
  logic [SW-1:0] sel;
  logic [IW-1:0] imm;
  logic [DW-1:0] ans, memin;
  logic          save, restore;
  logic [DW-1:0] acc, rdata;
  logic [15:0]   address;
  logic          busy, done;

  logic [2:0]  op2;
  logic [1:0]  sel2;
  logic [7:0]  imm2;
  logic [15:0] ans2, memin2;
  logic        save2, restore2;
  logic [15:0] acc2, rdata2;
  logic [31:0] address2;
  logic        busy2, done2;

  regfile_ctx #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .OP(op), .SEL(sel), .IMM(imm), .ANS(ans),
    .MEMIN(memin), .SAVE(save), .RESTORE(restore), .ACC(acc), .ADDRESS(address),
    .RDATA(rdata), .BUSY(busy), .DONE(done)
  );

  regfile_ctx #(.DATA_W(16), .NUM_REGS(4)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .OP(op2), .SEL(sel2), .IMM(imm2), .ANS(ans2),
    .MEMIN(memin2), .SAVE(save2), .RESTORE(restore2), .ACC(acc2), .ADDRESS(address2),
    .RDATA(rdata2), .BUSY(busy2), .DONE(done2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: live bank, shadow bank, snapshot taken when a save is accepted
  int m     [NR];
  int msh   [NR];
  int msnap [NR];
  int orig  [NR];
  int mode;       // 0 idle, 1 saving, 2 restoring
  int remaining;  // copy cycles still to go
  int exp_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m[i] = 0;
      msh[i] = 0;
      msnap[i] = 0;
    end
    mode = 0;
    remaining = 0;
    exp_done = 0;
  endtask

  task automatic model_edge(input int o, input int s, input int i, input int a,
                            input int mi, input bit sv, input bit rs);
    int p;
    exp_done = 0;
    if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        if (mode == 2) begin
          for (int k = 0; k < NR; k++) m[k] = msh[k];
        end else begin
          for (int k = 0; k < NR; k++) msh[k] = msnap[k];
        end
        exp_done = 1;
        mode = 0;
      end
    end else begin
      case (o)
        1: m[0] = (m[0] / 16) * 16 + i;
        2: m[0] = i * 16 + (m[0] % 16);
        3: m[0] = a;
        4: m[0] = m[s];
        5: m[s] = m[0];
        6: m[s] = mi;
        7: begin
          p = (m[1] * 256 + m[0] + 1) % 65536;
          m[0] = p % 256;
          m[1] = p / 256;
        end
        default: ;
      endcase
      if (sv) begin
        mode = 1;
        remaining = NR;
        for (int k = 0; k < NR; k++) msnap[k] = m[k];
      end else if (rs) begin
        mode = 2;
        remaining = NR;
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", {63'd0, busy}, (remaining > 0) ? 64'd1 : 64'd0);
    check("done", {63'd0, done}, 64'(exp_done));
    if (mode != 2) begin
      check("acc", {56'd0, acc}, 64'(m[0]));
      check("address", {48'd0, address}, 64'(m[1] * 256 + m[0]));
      check("rdata", {56'd0, rdata}, 64'(m[sel]));
    end
  endtask

  task automatic step(input int o, input int s, input int i, input int a,
                      input int mi, input bit sv, input bit rs);
    @(negedge CLK);
    op = o[2:0]; sel = s[SW-1:0]; imm = i[IW-1:0]; ans = a[DW-1:0];
    memin = mi[DW-1:0]; save = sv; restore = rs;
    @(posedge CLK);
    model_edge(o, s, i, a, mi, sv, rs);
    #1;
    check_outputs();
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) step(0, $urandom_range(0, NR - 1), 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    op = 3'd0; save = 1'b0; restore = 1'b0;
    op2 = 3'd0; save2 = 1'b0; restore2 = 1'b0;
    model_clear();
    #1;
    check_outputs();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic step2(input int o, input int s, input int i, input bit sv);
    @(negedge CLK);
    op2 = o[2:0]; sel2 = s[1:0]; imm2 = i[7:0]; save2 = sv;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int bc, dc;
    RESET_N = 1'b0;
    op = 3'd0; sel = '0; imm = '0; ans = '0; memin = '0; save = 1'b0; restore = 1'b0;
    op2 = 3'd0; sel2 = '0; imm2 = '0; ans2 = '0; memin2 = '0; save2 = 1'b0; restore2 = 1'b0;
    model_clear();
    do_reset();
    check("reset_acc", {56'd0, acc}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);

    // Immediate loads
    step(1, 0, 4'hA, 0, 0, 1'b0, 1'b0);
    step(2, 0, 4'h5, 0, 0, 1'b0, 1'b0);
    check("lli_lui_5a", {56'd0, acc}, 64'h5A);
    step(1, 0, 4'h3, 0, 0, 1'b0, 1'b0);
    check("lli_53", {56'd0, acc}, 64'h53);

    // Pointer increment wrap and carry
    step(1, 0, 4'hF, 0, 0, 1'b0, 1'b0);
    step(2, 0, 4'hF, 0, 0, 1'b0, 1'b0);
    step(5, 1, 0, 0, 0, 1'b0, 1'b0);
    step(7, 0, 0, 0, 0, 1'b0, 1'b0);
    check("inc_wrap", {48'd0, address}, 64'h0000);
    step(1, 0, 4'h2, 0, 0, 1'b0, 1'b0);
    step(2, 0, 4'h1, 0, 0, 1'b0, 1'b0);
    step(5, 1, 0, 0, 0, 1'b0, 1'b0);
    step(1, 0, 4'hF, 0, 0, 1'b0, 1'b0);
    step(2, 0, 4'hF, 0, 0, 1'b0, 1'b0);
    step(7, 0, 0, 0, 0, 1'b0, 1'b0);
    check("inc_carry", {48'd0, address}, 64'h1300);

    // MOV / ALU / TOACC round trip
    step(1, 0, 4'hC, 0, 0, 1'b0, 1'b0);
    step(2, 0, 4'h3, 0, 0, 1'b0, 1'b0);
    step(5, 7, 0, 0, 0, 1'b0, 1'b0);
    step(3, 0, 0, 8'h00, 0, 1'b0, 1'b0);
    check("alu_zero", {56'd0, acc}, 64'h00);
    step(4, 7, 0, 0, 0, 1'b0, 1'b0);
    check("toacc_3c", {56'd0, acc}, 64'h3C);
    step(0, 7, 0, 0, 0, 1'b0, 1'b0);
    check("rdata_r7", {56'd0, rdata}, 64'h3C);

    // Save a distinct bank; OPs while busy must not land
    for (int i = 0; i < NR; i++) begin
      orig[i] = (i * 37 + 5) % 256;
      step(6, i, 0, 0, orig[i], 1'b0, 1'b0);
    end
    bc = 0; dc = 0;
    step(0, 0, 0, 0, 0, 1'b1, 1'b0);
    bc += int'(busy);
    for (int j = 1; j < 20; j++) begin
      if (j < 16) step($urandom_range(1, 7), $urandom_range(0, NR - 1), $urandom_range(0, 15),
                       $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
      else step(0, 0, 0, 0, 0, 1'b0, 1'b0);
      bc += int'(busy);
      dc += int'(done);
    end
    check("save_busy_cycles", 64'(bc), 64'd16);
    check("save_done_pulses", 64'(dc), 64'd1);
    for (int i = 0; i < NR; i++) step(6, i, 0, 0, (~orig[i]) & 255, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    nops(18);
    for (int i = 0; i < NR; i++) begin
      step(0, i, 0, 0, 0, 1'b0, 1'b0);
      check("restore_reg", {56'd0, rdata}, 64'(orig[i]));
    end

    // SAVE and RESTORE together: save wins; a mid-copy request is dropped
    step(6, 0, 0, 0, 8'hEE, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b1, 1'b1);
    step(0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    nops(16);
    step(6, 0, 0, 0, 8'h11, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    nops(17);
    check("both_save_wins", {56'd0, acc}, 64'hEE);

    // Reset during copy cycle 5 aborts without DONE and clears the shadow
    step(0, 0, 0, 0, 0, 1'b1, 1'b0);
    nops(5);
    do_reset();
    check("midcopy_busy", {63'd0, busy}, 64'd0);
    nops(3);
    check("midcopy_no_done", {63'd0, done}, 64'd0);
    step(6, 3, 0, 0, 8'h77, 1'b0, 1'b0);
    step(0, 3, 0, 0, 0, 1'b0, 1'b1);
    nops(17);
    step(0, 3, 0, 0, 0, 1'b0, 1'b0);
    check("shadow_cleared", {56'd0, rdata}, 64'h00);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 7), $urandom_range(0, NR - 1), $urandom_range(0, 15),
           $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end
    nops(20);

    // Wide instance: byte immediates, 32-bit pointer wrap, 4-cycle copy
    step2(1, 0, 8'hAB, 1'b0);
    check("w_lli", {48'd0, acc2}, 64'h00AB);
    step2(2, 0, 8'hCD, 1'b0);
    check("w_lui", {48'd0, acc2}, 64'hCDAB);
    step2(1, 0, 8'hFF, 1'b0);
    step2(2, 0, 8'hFF, 1'b0);
    step2(5, 1, 0, 1'b0);
    check("w_ptr_full", {32'd0, address2}, 64'hFFFFFFFF);
    step2(7, 0, 0, 1'b0);
    check("w_inc_wrap", {32'd0, address2}, 64'h0);
    bc = 0; dc = 0;
    step2(0, 0, 0, 1'b1);
    bc += int'(busy2);
    for (int j = 0; j < 7; j++) begin
      step2(0, 0, 0, 1'b0);
      bc += int'(busy2);
      dc += int'(done2);
    end
    check("w_save_cycles", 64'(bc), 64'd4);
    check("w_done_pulses", 64'(dc), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_ctx.md
# regfile_ctx

Parametrised successor to the CPU's accumulator register file. Holds `NUM_REGS` × `DATA_W` registers with R0 as accumulator and {R1,R0} as memory address pointer. Executes one register operation per cycle and adds a pointer post-increment plus a shadow bank with multi-cycle context SAVE/RESTORE for interrupt entry and exit. Sits between the instruction decoder, the ALU (`ANS`) and the memory interface.

## Interface
Parameters:
- `DATA_W`, 8, register width; must be even and ≥4
- `NUM_REGS`, 16, register count; must be a power of two and ≥2
- `IMM_W`, `DATA_W/2`, immediate nibble width; derived, not overridable

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `OP`  in  3  register operation code (encodings in package)
- `SEL`  in  log2(NUM_REGS)  register index
- `IMM`  in  IMM_W  immediate for LLI/LUI
- `ANS`  in  DATA_W  ALU result
- `MEMIN`  in  DATA_W  memory read data
- `SAVE`  in  1  request: copy live bank to shadow
- `RESTORE`  in  1  request: copy shadow bank to live
- `ACC`  out  DATA_W  R0
- `ADDRESS`  out  2·DATA_W  {R1,R0}
- `RDATA`  out  DATA_W  R[SEL], combinational; also serves as memory write data
- `BUSY`  out  1  copy in progress
- `DONE`  out  1  one-cycle pulse when a copy completes

## Operation
- OP codes:
  - NOP: no register change.
  - LLI: R0 ← {R0[DATA_W-1:IMM_W], IMM}.
  - LUI: R0 ← {IMM, R0[IMM_W-1:0]}.
  - ALU: R0 ← ANS.
  - TOACC: R0 ← R[SEL].
  - MOV: R[SEL] ← R0.
  - LOAD: R[SEL] ← MEMIN.
  - INC: {R1,R0} ← {R1,R0}+1 mod 2^(2·DATA_W); 0xFFFF wraps to 0x0000 at 8 bits.
- MOV/LOAD with SEL=0 write R0 (the accumulator). TOACC with SEL=0 leaves R0 unchanged.
- FSM states:
  - IDLE: SAVE → SAVING; RESTORE → RESTORING. SAVE and RESTORE together → SAVING (SAVE wins).
  - SAVING / RESTORING: copy one register per cycle, index 0 up to NUM_REGS-1, then → IDLE.
- While BUSY:
  - OP is ignored (treated as NOP).
  - New SAVE/RESTORE requests are ignored, not queued.
- An OP presented in the same cycle as an accepted request executes at that edge. The copy then sees the post-OP value.
- RDATA/ACC/ADDRESS always reflect the live bank, including during a RESTORE in progress.
- Reset clears all live and shadow registers, FSM → IDLE, copy index → 0, BUSY=0, DONE=0. Reset mid-copy aborts the copy with no DONE.

## Timing
- Reset values: ACC=0, ADDRESS=0, RDATA=0, BUSY=0, DONE=0.
- Register OP latency is 1 cycle: the result is visible on outputs after the capturing edge.
- Copy sequence, request sampled at edge k:
  - BUSY is high after edge k through edge k+NUM_REGS, i.e. exactly NUM_REGS cycles.
  - Edge k+1+i copies register i.
  - DONE is high for the single cycle following edge k+NUM_REGS, the same cycle BUSY falls.
- A new request may be accepted in the DONE cycle. Back-to-back copies have no gap beyond that.
- RDATA is a combinational read. A write to R[SEL] is visible on RDATA only after the edge (no bypass).

## Structure
- Shared package `regfile_ctx_pkg`:
  - OP encoding enum: NOP=0, LLI=1, LUI=2, ALU=3, TOACC=4, MOV=5, LOAD=6, INC=7.
  - FSM state enum: IDLE, SAVING, RESTORING.
- Sub-module `ctx_copy_fsm` owns the state, copy index, BUSY and DONE. It outputs the copy enable, direction and index.
- Top level owns both banks and the OP datapath.

## Test plan
- Reset then LLI IMM=0xA, LUI IMM=0x5 → ACC=0x5A. A second LLI IMM=0x3 → ACC=0x53.
- R0=0xFF, R1=0xFF, INC → ADDRESS=0x0000. From 0x12FF, INC → 0x1300.
- MOV SEL=7 with ACC=0x3C, then ALU ANS=0x00, then TOACC SEL=7 → ACC=0x3C. Check RDATA with SEL=7 reads 0x3C.
- Load distinct values into R0..R15, SAVE:
  - BUSY high for 16 cycles, DONE single pulse.
  - Overwrite all registers, RESTORE → original values back.
  - OPs issued while BUSY produce no change.
- SAVE and RESTORE asserted together → SAVING. A request asserted mid-copy is ignored. RESET_N low at copy cycle 5 → all zero, no DONE.
- DATA_W=16, NUM_REGS=4: LLI/LUI operate on bytes. INC wraps 0xFFFFFFFF → 0. SAVE takes 4 cycles.
